// File: rtl/usb_pkg.sv
// Constants shared by the USB full-speed TX and RX line paths.
package usb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'h0,
        ST_SYNC = 4'h1,
        ST_DATA = 4'h2,
        ST_ERR  = 4'h3,
        ST_EOP  = 4'h4
    } usb_state_t;

    localparam logic [2:0] USB_STUFF_LIMIT = 3'd6;
    localparam logic [2:0] SYNC_MIN_ZEROS  = 3'd5;

endpackage

// File: rtl/usb_rx_nrzi.sv
// NRZI decoder with consecutive-ones tracking for receive-side bit unstuffing.
module usb_rx_nrzi
    import usb_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    input  logic i_se0,
    input  logic i_d_valid,
    input  logic i_ones_load,
    input  logic i_ones_step,
    output logic o_decoded,
    output logic o_stuff_bit,
    output logic o_stuff_err
);

    logic       r_prev_line;
    logic [2:0] r_ones_cnt;
    logic       w_at_limit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_line <= 1'b1;
            r_ones_cnt  <= '0;
        end else begin
            if (i_d_valid && !i_se0) begin
                r_prev_line <= i_d;
            end
            // A stuffed zero steps with decoded 0, which clears the run as required.
            if (i_ones_load) begin
                r_ones_cnt <= 3'd1;
            end else if (i_ones_step) begin
                r_ones_cnt <= o_decoded ? r_ones_cnt + 3'd1 : '0;
            end
        end
    end

    always_comb begin
        o_decoded   = (i_d == r_prev_line);
        w_at_limit  = (r_ones_cnt == USB_STUFF_LIMIT);
        o_stuff_bit = w_at_limit & ~o_decoded;
        o_stuff_err = w_at_limit & o_decoded;
    end

endmodule

// File: rtl/usb_rx_unstuff.sv
// Full-speed USB receive path: SYNC detection, bit unstuffing and LSB-first
// byte assembly on top of the NRZI decoder.
module usb_rx_unstuff
    import usb_pkg::*;
(
    input  logic       c,
    input  logic       rst_n,
    input  logic       d,
    input  logic       se0,
    input  logic       d_valid,
    output logic [7:0] q,
    output logic       q_valid,
    output logic       q_eop,
    output logic       q_err,
    output logic       active
);

    usb_state_t r_state;
    usb_state_t w_state_nxt;

    logic [2:0] r_zero_cnt;
    logic [2:0] w_zero_cnt_nxt;
    logic [2:0] r_bit_cnt;
    logic [2:0] w_bit_cnt_nxt;
    logic [7:0] r_shreg;
    logic [7:0] w_shreg_nxt;

    logic [7:0] r_q;
    logic       r_q_valid;
    logic       r_q_eop;
    logic       r_q_err;
    logic       r_active;

    logic w_decoded;
    logic w_stuff_bit;
    logic w_stuff_err;
    logic w_ones_load;
    logic w_ones_step;
    logic w_load_q;
    logic w_eop;
    logic w_err;

    usb_rx_nrzi u_nrzi (
        .i_clk       (c),
        .i_rst_n     (rst_n),
        .i_d         (d),
        .i_se0       (se0),
        .i_d_valid   (d_valid),
        .i_ones_load (w_ones_load),
        .i_ones_step (w_ones_step),
        .o_decoded   (w_decoded),
        .o_stuff_bit (w_stuff_bit),
        .o_stuff_err (w_stuff_err)
    );

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_zero_cnt_nxt = r_zero_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shreg_nxt    = r_shreg;
        w_ones_load    = 1'b0;
        w_ones_step    = 1'b0;
        w_load_q       = 1'b0;
        w_eop          = 1'b0;
        w_err          = 1'b0;

        if (d_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (!se0 && !w_decoded) begin
                        w_state_nxt    = ST_SYNC;
                        w_zero_cnt_nxt = 3'd1;
                    end
                end
                ST_SYNC: begin
                    if (se0) begin
                        w_state_nxt = ST_IDLE;
                    end else if (!w_decoded) begin
                        if (r_zero_cnt != 3'd7) begin
                            w_zero_cnt_nxt = r_zero_cnt + 3'd1;
                        end
                    end else if (r_zero_cnt >= SYNC_MIN_ZEROS) begin
                        w_state_nxt   = ST_DATA;
                        w_ones_load   = 1'b1;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (se0) begin
                        w_state_nxt = ST_EOP;
                        w_eop       = 1'b1;
                    end else if (w_stuff_bit) begin
                        w_ones_step = 1'b1;
                    end else if (w_stuff_err) begin
                        w_state_nxt = ST_ERR;
                        w_err       = 1'b1;
                    end else begin
                        w_ones_step   = 1'b1;
                        w_shreg_nxt   = {w_decoded, r_shreg[7:1]};
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        w_load_q      = (r_bit_cnt == 3'd7);
                    end
                end
                ST_ERR: begin
                    if (se0) begin
                        w_state_nxt = ST_EOP;
                    end
                end
                ST_EOP: begin
                    if (!se0) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            r_zero_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            r_q        <= '0;
            r_q_valid  <= 1'b0;
            r_q_eop    <= 1'b0;
            r_q_err    <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_zero_cnt <= w_zero_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shreg    <= w_shreg_nxt;
            if (w_load_q) begin
                r_q <= w_shreg_nxt;
            end
            r_q_valid  <= w_load_q;
            r_q_eop    <= w_eop;
            r_q_err    <= w_err;
            r_active   <= (w_state_nxt == ST_DATA);
        end
    end

    assign q       = r_q;
    assign q_valid = r_q_valid;
    assign q_eop   = r_q_eop;
    assign q_err   = r_q_err;
    assign active  = r_active;

endmodule

// File: tb/tb_usb_rx_unstuff.sv
// Bench for usb_rx_unstuff: a transmitter-side model builds NRZI/stuffed line
// traffic from intended bytes and predicts every output cycle.
module tb_usb_rx_unstuff;

    logic       c = 1'b0;
    logic       rst_n = 1'b0;
    logic       d = 1'b1;
    logic       se0 = 1'b0;
    logic       d_valid = 1'b0;
    logic [7:0] q;
    logic       q_valid;
    logic       q_eop;
    logic       q_err;
    logic       active;

    usb_rx_unstuff dut (
        .c       (c),
        .rst_n   (rst_n),
        .d       (d),
        .se0     (se0),
        .d_valid (d_valid),
        .q       (q),
        .q_valid (q_valid),
        .q_eop   (q_eop),
        .q_err   (q_err),
        .active  (active)
    );

    always #5 c = ~c;

    int n_pass = 0;
    int n_tot  = 0;

    logic [7:0] exp_q   = '0;
    logic       exp_qv  = 1'b0;
    logic       exp_eop = 1'b0;
    logic       exp_err = 1'b0;
    logic       exp_act = 1'b0;
    bit         chk_en  = 1'b0;

    // transmitter-side view: line level, ones run, byte accumulator
    logic       lvl = 1'b1;
    int         run = 0;
    logic [7:0] acc = '0;
    int         nb = 0;
    bit         in_data = 1'b0;

    int         n_qv = 0, n_eop = 0, n_err = 0, n_act = 0, n_strb = 0;
    logic [7:0] last_q = '0;
    logic       sync_line[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tot++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, want);
    endtask

    always @(negedge c) begin
        if (chk_en) begin
            check("q_valid", {31'd0, q_valid}, {31'd0, exp_qv});
            check("q_eop",   {31'd0, q_eop},   {31'd0, exp_eop});
            check("q_err",   {31'd0, q_err},   {31'd0, exp_err});
            check("active",  {31'd0, active},  {31'd0, exp_act});
            check("q",       {24'd0, q},       {24'd0, exp_q});
            if (q_valid) begin n_qv++; last_q = q; end
            if (q_eop)  n_eop++;
            if (q_err)  n_err++;
            if (active) n_act++;
        end
    end

    task automatic strobe(input logic dd, input logic s, input logic ev_v, input logic [7:0] ev_q,
                          input logic ev_eop, input logic ev_err, input logic ev_act);
        @(posedge c); #1;
        d = dd; se0 = s; d_valid = 1'b1;
        n_strb++;
        @(posedge c); #1;
        d_valid = 1'b0;
        exp_qv = ev_v;
        if (ev_v) exp_q = ev_q;
        exp_eop = ev_eop;
        exp_err = ev_err;
        exp_act = ev_act;
        @(posedge c); #1;
        exp_qv = 1'b0; exp_eop = 1'b0; exp_err = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge c);
    endtask

    task automatic tx_dec(input logic b, input logic ev_v, input logic [7:0] ev_q,
                          input logic ev_err, input logic ev_act);
        logic dd;
        dd  = b ? lvl : ~lvl;
        lvl = dd;
        strobe(dd, 1'b0, ev_v, ev_q, 1'b0, ev_err, ev_act);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tx_dec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_sync(input int nz);
        bit ok;
        ok = (nz >= 5);
        for (int i = 0; i < nz; i++) begin
            tx_dec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            sync_line.push_back(lvl);
        end
        tx_dec(1'b1, 1'b0, 8'h00, 1'b0, ok);
        sync_line.push_back(lvl);
        if (ok) begin in_data = 1'b1; run = 1; nb = 0; acc = '0; end
    endtask

    task automatic data_bit(input logic b, input bit stuff_ok);
        logic v;
        acc = {b, acc[7:1]};
        nb++;
        v = 1'b0;
        if (nb == 8) begin v = 1'b1; nb = 0; end
        run = b ? run + 1 : 0;
        tx_dec(b, v, acc, 1'b0, 1'b1);
        if (stuff_ok && run == 6) begin
            tx_dec(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            run = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] x);
        for (int i = 0; i < 8; i++) data_bit(x[i], 1'b1);
    endtask

    task automatic send_eop();
        strobe(1'($urandom_range(0, 1)), 1'b1, 1'b0, 8'h00, in_data, 1'b0, 1'b0);
        in_data = 1'b0;
        strobe(1'($urandom_range(0, 1)), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        lvl = 1'b1;
        strobe(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_err();
        logic dd;
        while (run < 6) data_bit(1'b1, 1'b0);
        tx_dec(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        in_data = 1'b0;
        repeat ($urandom_range(0, 3)) begin
            dd = 1'($urandom_range(0, 1));
            lvl = dd;
            strobe(dd, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        send_eop();
    endtask

    task automatic reset_mid();
        @(posedge c); #2;
        rst_n = 1'b0;
        exp_q = '0; exp_qv = 1'b0; exp_eop = 1'b0; exp_err = 1'b0; exp_act = 1'b0;
        #1;
        check("async_rst_q",      {24'd0, q}, 32'd0);
        check("async_rst_valid",  {31'd0, q_valid}, 32'd0);
        check("async_rst_eop",    {31'd0, q_eop}, 32'd0);
        check("async_rst_err",    {31'd0, q_err}, 32'd0);
        check("async_rst_active", {31'd0, active}, 32'd0);
        @(posedge c); #1;
        rst_n = 1'b1;
        lvl = 1'b1; run = 0; nb = 0; acc = '0; in_data = 1'b0;
    endtask

    task automatic clr_counts();
        n_qv = 0; n_eop = 0; n_err = 0; n_act = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] sl;
        int         s0;
        int         r;

        repeat (3) @(posedge c);
        #1;
        check("reset_q",      {24'd0, q}, 32'd0);
        check("reset_valid",  {31'd0, q_valid}, 32'd0);
        check("reset_eop",    {31'd0, q_eop}, 32'd0);
        check("reset_err",    {31'd0, q_err}, 32'd0);
        check("reset_active", {31'd0, active}, 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // basic packet 0xA5
        idle(3);
        clr_counts();
        sync_line.delete();
        send_sync(7);
        for (int i = 0; i < 8; i++) sl[7 - i] = sync_line[i];
        check("sync_line_pattern", {24'd0, sl}, 32'h54);
        send_byte(8'hA5);
        send_eop();
        check("a5_valid_count", n_qv, 1);
        check("a5_byte", {24'd0, last_q}, 32'hA5);
        check("a5_eop_count", n_eop, 1);

        // 0xFF needs one stuffed zero after the fifth data one
        idle(2);
        clr_counts();
        send_sync(7);
        s0 = n_strb;
        send_byte(8'hFF);
        check("ff_line_bits", n_strb - s0, 9);
        send_eop();
        check("ff_valid_count", n_qv, 1);
        check("ff_byte", {24'd0, last_q}, 32'hFF);
        check("ff_err_count", n_err, 0);

        // seven ones with no stuffing
        idle(2);
        clr_counts();
        send_sync(7);
        send_err();
        check("err_err_count", n_err, 1);
        check("err_valid_count", n_qv, 0);
        check("err_eop_count", n_eop, 0);

        // truncated SYNC then a good one with 0x3C
        idle(2);
        clr_counts();
        send_sync(3);
        check("short_sync_active", n_act, 0);
        idle(2);
        send_sync(7);
        send_byte(8'h3C);
        send_eop();
        check("3c_valid_count", n_qv, 1);
        check("3c_byte", {24'd0, last_q}, 32'h3C);

        // 0x12 followed by a partial byte
        idle(2);
        clr_counts();
        send_sync(7);
        send_byte(8'h12);
        for (int i = 0; i < 3; i++) data_bit(1'($urandom_range(0, 1)), 1'b1);
        send_eop();
        check("12_valid_count", n_qv, 1);
        check("12_byte", {24'd0, last_q}, 32'h12);
        check("12_eop_count", n_eop, 1);

        // reset mid-byte, then 0xC3
        idle(2);
        send_sync(7);
        for (int i = 0; i < 4; i++) data_bit(1'($urandom_range(0, 1)), 1'b1);
        reset_mid();
        clr_counts();
        idle(2);
        send_sync(7);
        send_byte(8'hC3);
        send_eop();
        check("c3_valid_count", n_qv, 1);
        check("c3_byte", {24'd0, last_q}, 32'hC3);

        // randomized traffic
        repeat (40) begin
            r = $urandom_range(0, 9);
            idle($urandom_range(1, 3));
            if (r == 0) begin
                send_sync($urandom_range(1, 4));
            end else if (r == 1) begin
                send_sync($urandom_range(5, 7));
                repeat ($urandom_range(0, 2)) send_byte(8'($urandom));
                repeat ($urandom_range(0, 5)) data_bit(1'($urandom_range(0, 1)), 1'b1);
                send_err();
            end else if (r == 2) begin
                send_sync($urandom_range(5, 7));
                repeat ($urandom_range(0, 12)) data_bit(1'($urandom_range(0, 1)), 1'b1);
                reset_mid();
            end else begin
                send_sync($urandom_range(5, 7));
                repeat ($urandom_range(1, 4)) send_byte(8'($urandom));
                repeat ($urandom_range(0, 7)) data_bit(1'($urandom_range(0, 1)), 1'b1);
                send_eop();
            end
        end

        idle(2);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
